// File: rtl/prog_loader_if.sv
// Loader/CPU-side bus for prog_loader: control, byte-stream refill port and
// instruction fetch port grouped into one bundle.
interface prog_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              load_req;
    logic              start;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_run;
    logic              loading;
    logic              load_done;

    modport master (
        output load_req, start, s_valid, s_data, mem_addr,
        input  s_ready, mem_data, cpu_run, loading, load_done
    );

    modport slave (
        input  load_req, start, s_valid, s_data, mem_addr,
        output s_ready, mem_data, cpu_run, loading, load_done
    );
endinterface

// File: rtl/prog_loader.sv
// Program store for the 4-bit CPU: 16-entry instruction memory with a
// combinational fetch port and a byte-stream loader that holds the CPU in reset.
//
// state | meaning
// HALT  | idle after reset, CPU held; waits for load_req or start
// LOAD  | accepting program bytes into mem[wptr], CPU held
// RUN   | CPU released and fetching
module prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W:0]   wptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              cpu_run_q;
    logic              load_done_q;

    // A pending load_req blocks acceptance so a restart never writes a stale byte.
    assign bus.s_ready   = (state_q == LOAD) && !bus.load_req;
    assign bus.loading   = (state_q == LOAD);
    assign bus.mem_data  = mem_q[bus.mem_addr];
    assign bus.cpu_run   = cpu_run_q;
    assign bus.load_done = load_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HALT;
            wptr_q      <= '0;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                HALT: begin
                    if (bus.load_req) begin
                        state_q <= LOAD;
                        wptr_q  <= '0;
                    end else if (bus.start) begin
                        state_q   <= RUN;
                        cpu_run_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.load_req) begin
                        wptr_q <= '0;
                    end else if (bus.s_valid) begin
                        mem_q[wptr_q[ADDR_W-1:0]] <= bus.s_data;
                        wptr_q <= wptr_q + 1'b1;
                        if (wptr_q == LAST) begin
                            state_q     <= RUN;
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // cpu_run drops on the sampling edge so the CPU restarts from ip=0.
                    if (bus.load_req) begin
                        state_q   <= LOAD;
                        wptr_q    <= '0;
                        cpu_run_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= HALT;
                    cpu_run_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader against a behavioural model of the
// program store (array of bytes, fill count, operating mode).
module tb_prog_loader;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {M_STOPPED, M_FILLING, M_RUNNING} mode_e;
    mode_e      mode;
    logic [7:0] ref_mem [DEPTH];
    int         fill;
    bit         exp_done;
    int         vectors    = 0;
    int         miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode     = M_STOPPED;
        fill     = 0;
        exp_done = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    endtask

    // One clock: check pre-edge combinational outputs, advance the model, check post-edge outputs.
    task automatic step(output bit took);
        #1;
        chk("s_ready", bus.s_ready, (mode == M_FILLING) && !bus.load_req);
        chk("mem_data", bus.mem_data, ref_mem[bus.mem_addr]);
        took     = 1'b0;
        exp_done = 1'b0;
        if (mode == M_STOPPED) begin
            if (bus.load_req) begin mode = M_FILLING; fill = 0; end
            else if (bus.start) mode = M_RUNNING;
        end else if (mode == M_FILLING) begin
            if (bus.load_req) fill = 0;
            else if (bus.s_valid) begin
                ref_mem[fill] = bus.s_data;
                fill++;
                took = 1'b1;
                if (fill == DEPTH) begin mode = M_RUNNING; exp_done = 1'b1; end
            end
        end else if (bus.load_req) begin
            mode = M_FILLING;
            fill = 0;
        end
        @(posedge clk);
        #1;
        chk("cpu_run", bus.cpu_run, mode == M_RUNNING);
        chk("loading", bus.loading, mode == M_FILLING);
        chk("load_done", bus.load_done, exp_done);
    endtask

    task automatic idle_inputs();
        bus.load_req = 1'b0;
        bus.start    = 1'b0;
        bus.s_valid  = 1'b0;
        bus.s_data   = 8'h00;
    endtask

    task automatic pulse_load_req();
        bit took;
        bus.load_req = 1'b1;
        step(took);
        bus.load_req = 1'b0;
    endtask

    // Streams bytes until the model finishes a load (bounded); counts DUT s_ready and load_done.
    task automatic stream(input bit throttle, input bit rnd, input logic [7:0] base, input bit incr,
                          output int ready_cnt, output int done_cnt);
        bit took;
        int n = 0;
        ready_cnt = 0;
        done_cnt  = 0;
        for (int c = 0; c < 300 && mode != M_RUNNING; c++) begin
            bus.s_valid  = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.s_data   = rnd ? 8'($urandom) : (incr ? base + 8'(n) : base);
            bus.mem_addr = 4'($urandom_range(0, 15));
            #1;
            if (bus.s_ready === 1'b1) ready_cnt++;
            step(took);
            if (took) n++;
            if (bus.load_done === 1'b1) done_cnt++;
        end
        bus.s_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step(took);
            if (bus.load_done === 1'b1) done_cnt++;
        end
        chk("bytes_taken", n, 16);
    endtask

    task automatic read_all(input bit use_lit, input logic [7:0] lit);
        bit took;
        for (int a = 0; a < DEPTH; a++) begin
            bus.mem_addr = 4'(a);
            #1;
            if (use_lit) chk("mem_lit", bus.mem_data, lit);
            step(took);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  rdy, dn;
        bit  took;
        idle_inputs();
        bus.mem_addr = '0;
        model_reset();

        // Reset held: every output low.
        #12;
        chk("rst_cpu_run", bus.cpu_run, 1'b0);
        chk("rst_loading", bus.loading, 1'b0);
        chk("rst_load_done", bus.load_done, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_mem_data", bus.mem_data, 8'h00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        read_all(1'b1, 8'h00);

        // Back-to-back load 0x30..0x3F.
        pulse_load_req();
        stream(1'b0, 1'b0, 8'h30, 1'b1, rdy, dn);
        chk("b2b_ready_cycles", rdy, 16);
        chk("b2b_done_pulses", dn, 1);
        for (int a = 0; a < DEPTH; a++) begin
            bus.mem_addr = 4'(a);
            #1;
            chk("b2b_mem", bus.mem_data, 8'h30 + 8'(a));
        end

        // Throttled random load (also a reload from RUN).
        pulse_load_req();
        chk("halt_on_reload", bus.cpu_run, 1'b0);
        stream(1'b1, 1'b1, 8'h00, 1'b0, rdy, dn);
        chk("thr_done_pulses", dn, 1);
        read_all(1'b0, 8'h00);

        // Restart mid-load.
        pulse_load_req();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        for (int i = 0; i < 5; i++) step(took);
        bus.load_req = 1'b1;
        #1;
        chk("restart_s_ready", bus.s_ready, 1'b0);
        step(took);
        bus.load_req = 1'b0;
        stream(1'b0, 1'b0, 8'h55, 1'b0, rdy, dn);
        chk("restart_done_pulses", dn, 1);
        read_all(1'b1, 8'h55);

        // start in RUN is ignored; reload then runs again.
        bus.start = 1'b1;
        step(took);
        bus.start = 1'b0;
        chk("start_in_run", bus.cpu_run, 1'b1);
        pulse_load_req();
        stream(1'b1, 1'b1, 8'h00, 1'b0, rdy, dn);
        chk("reload_running", bus.cpu_run, 1'b1);

        // start in HALT releases without loading.
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        step(took);
        bus.start = 1'b0;
        chk("start_in_halt", bus.cpu_run, 1'b1);

        // Reset mid-load after 8 bytes.
        pulse_load_req();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.s_data = 8'($urandom_range(1, 255));
            step(took);
        end
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_loading", bus.loading, 1'b0);
        chk("midrst_s_ready", bus.s_ready, 1'b0);
        chk("midrst_cpu_run", bus.cpu_run, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        read_all(1'b1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
